if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 PC_IF  output  32  current fetch PC register.
REQ-005 PC_Plus_4_IF  output  32  PC_IF + 4, combinational.
REQ-006 Imem_Req_IF  output  1  instruction-memory request.
REQ-007 Imem_Addr_IF  output  32  request address; equals PC_IF.
REQ-008 Imem_Ack_IF  input  1  one-cycle acknowledge; Imem_Data_IF valid in that cycle.
REQ-009 Imem_Data_IF  input  32  fetched instruction word.
REQ-010 Instr_IF  output  32  buffered instruction to IF/ID.
REQ-011 Instr_PC_IF  output  32  address of Instr_IF.
REQ-012 Instr_Valid_IF  output  1  output buffer holds a valid instruction.
REQ-013 Instr_Ready_ID  input  1  ID accepts Instr_IF this cycle (low = hazard stall).
REQ-014 Jump_control_ID  input  1  jump redirect, one-cycle pulse.
REQ-015 Jump_dst_ID  input  32  jump target.
REQ-016 PCSrc_ID  input  1  taken-branch redirect, one-cycle pulse.
REQ-017 Branch_Dest_ID  input  32  branch target.
REQ-018 Flush_IF_ID  output  1  combinational; high in any cycle a redirect is accepted.
REQ-019 Fetch_Count_IF  output  32  count of instructions handed to ID (valid & ready), wraps 0xFFFF_FFFF->0.

Function
REQ-020 States: IDLE, FETCH, DRAIN; 2-bit encoded register.
REQ-021 IDLE: Imem_Req_IF=0; unconditional transition to FETCH next cycle.
REQ-022 FETCH: Imem_Req_IF=1 when buffer empty or (Instr_Valid_IF & Instr_Ready_ID), else 0.
REQ-023 Once Imem_Req_IF rises, Req and Imem_Addr_IF held stable until the cycle Imem_Ack_IF=1 (inclusive).
REQ-024 FETCH, Ack, no redirect: next cycle Instr_IF=Imem_Data_IF, Instr_PC_IF=old PC_IF, Instr_Valid_IF=1, PC_IF=PC_IF+4 (mod 2^32); zero-wait ack gives one instruction per cycle.
REQ-025 Buffer consumed (Valid & Ready) with no new ack: Instr_Valid_IF=0 next cycle; Fetch_Count_IF increments on every Valid & Ready cycle.
REQ-026 Redirect priority: Jump_control_ID over PCSrc_ID over sequential; target bits [1:0] forced to 2'b00.
REQ-027 Redirect accepted in any state except IDLE; Flush_IF_ID=1 same cycle; Instr_Valid_IF=0 next cycle; no Fetch_Count_IF increment that cycle even if Ready.
REQ-028 Redirect with no outstanding request, or coincident with Ack: Ack data discarded; PC_IF=target next cycle; state FETCH.
REQ-029 Redirect while request outstanding and no Ack: target stored in pending register; state DRAIN.
REQ-030 DRAIN: Req held per REQ-023; on Ack data discarded, PC_IF=pending target, state FETCH.
REQ-031 Redirect during DRAIN overwrites pending target (latest wins); redirect coincident with DRAIN Ack uses new target.
REQ-032 Redirect in IDLE ignored; Flush_IF_ID=0.

Reset
REQ-033 reset=0 at clock edge: state=IDLE, PC_IF=RESET_PC, Instr_IF=0, Instr_PC_IF=0, Instr_Valid_IF=0, Imem_Req_IF=0, Fetch_Count_IF=0, pending target=0.
REQ-034 Reset mid-request abandons the outstanding request; any Ack in the first cycle after reset release ignored.
REQ-035 First request (addr RESET_PC) issued second cycle after reset release.

Verification
REQ-036 Reset release, Ack tied high, Ready high -> Imem_Addr_IF 0x0,0x4,0x8,...; Instr_Valid_IF from cycle 3; Fetch_Count_IF=N after N accepts.
REQ-037 Ack delayed 3 cycles -> Req/Addr stable 4 cycles; one instruction buffered; PC advances by 4 exactly once.
REQ-038 Ready low 5 cycles with valid buffer -> Req=0, Instr_IF/Instr_PC_IF held, count frozen; Ready high resumes sequence.
REQ-039 Jump_control_ID=1, PCSrc_ID=1 same cycle, Jump_dst_ID=0x400, Branch_Dest_ID=0x800 -> Flush=1, PC_IF=0x400 next cycle.
REQ-040 Branch to 0x1002 while Ack pending -> DRAIN, stale data dropped, next Imem_Addr_IF=0x1000; second redirect to 0x2000 inside DRAIN -> 0x2000 used.
REQ-041 PC_IF=0xFFFF_FFFC, Ack -> PC_IF=0x0000_0000; reset low during outstanding request -> all REQ-033 values next cycle.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: sequential PC generation, single-entry instruction buffer
// toward ID, and jump/branch redirect with drain of an in-flight memory request.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC_IF,
    output logic [31:0] PC_Plus_4_IF,
    output logic        Imem_Req_IF,
    output logic [31:0] Imem_Addr_IF,
    input  logic        Imem_Ack_IF,
    input  logic [31:0] Imem_Data_IF,
    output logic [31:0] Instr_IF,
    output logic [31:0] Instr_PC_IF,
    output logic        Instr_Valid_IF,
    input  logic        Instr_Ready_ID,
    input  logic        Jump_control_ID,
    input  logic [31:0] Jump_dst_ID,
    input  logic        PCSrc_ID,
    input  logic [31:0] Branch_Dest_ID,
    output logic        Flush_IF_ID,
    output logic [31:0] Fetch_Count_IF
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pending_q, pending_d;

    logic        req;
    logic        ack;
    logic        accept;
    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;

    // Request stays high until acked: PC only moves on ack, and a consumed buffer
    // leaves it empty, so the condition cannot drop while a request is in flight.
    assign req        = ((state_q == FETCH) && (!valid_q || Instr_Ready_ID)) ||
                        (state_q == DRAIN);
    assign ack        = Imem_Ack_IF && req;
    assign accept     = valid_q && Instr_Ready_ID;
    assign redirect   = (Jump_control_ID || PCSrc_ID) && (state_q != IDLE);
    assign target_raw = Jump_control_ID ? Jump_dst_ID : Branch_Dest_ID;
    assign target     = {target_raw[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        pending_d  = pending_q;
        count_d    = (accept && !redirect) ? count_q + 32'd1 : count_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    if (req && !ack) begin
                        pending_d = target;
                        state_d   = DRAIN;
                    end else begin
                        pc_d = target;
                    end
                end else if (ack) begin
                    instr_d    = Imem_Data_IF;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end else if (accept) begin
                    valid_d = 1'b0;
                end
            end
            DRAIN: begin
                valid_d = 1'b0;
                if (redirect) begin
                    pending_d = target;
                end
                // Data returned for the abandoned address is dropped.
                if (ack) begin
                    pc_d    = redirect ? target : pending_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            valid_q    <= 1'b0;
            count_q    <= 32'h0;
            pending_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
        end
    end

    assign PC_IF          = pc_q;
    assign PC_Plus_4_IF   = pc_q + 32'd4;
    assign Imem_Req_IF    = req;
    assign Imem_Addr_IF   = pc_q;
    assign Instr_IF       = instr_q;
    assign Instr_PC_IF    = instr_pc_q;
    assign Instr_Valid_IF = valid_q;
    assign Flush_IF_ID    = redirect;
    assign Fetch_Count_IF = count_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl; each task covers one scenario.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_IF, PC_Plus_4_IF, Imem_Addr_IF, Instr_IF, Instr_PC_IF, Fetch_Count_IF;
    logic        Imem_Req_IF, Instr_Valid_IF, Flush_IF_ID;
    logic        Imem_Ack_IF, Instr_Ready_ID, Jump_control_ID, PCSrc_ID;
    logic [31:0] Imem_Data_IF, Jump_dst_ID, Branch_Dest_ID;

    int checks = 0;
    int errors = 0;

    if_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .PC_IF          (PC_IF),
        .PC_Plus_4_IF   (PC_Plus_4_IF),
        .Imem_Req_IF    (Imem_Req_IF),
        .Imem_Addr_IF   (Imem_Addr_IF),
        .Imem_Ack_IF    (Imem_Ack_IF),
        .Imem_Data_IF   (Imem_Data_IF),
        .Instr_IF       (Instr_IF),
        .Instr_PC_IF    (Instr_PC_IF),
        .Instr_Valid_IF (Instr_Valid_IF),
        .Instr_Ready_ID (Instr_Ready_ID),
        .Jump_control_ID(Jump_control_ID),
        .Jump_dst_ID    (Jump_dst_ID),
        .PCSrc_ID       (PCSrc_ID),
        .Branch_Dest_ID (Branch_Dest_ID),
        .Flush_IF_ID    (Flush_IF_ID),
        .Fetch_Count_IF (Fetch_Count_IF)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        Imem_Ack_IF     = 1'b0;
        Imem_Data_IF    = 32'h0;
        Instr_Ready_ID  = 1'b1;
        Jump_control_ID = 1'b0;
        Jump_dst_ID     = 32'h0;
        PCSrc_ID        = 1'b0;
        Branch_Dest_ID  = 32'h0;
    endtask

    // Leaves the bench one step after the last reset edge, with reset released (IDLE cycle).
    task automatic do_reset;
        clear_in();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        clear_in();
        reset = 1'b0;
        Imem_Ack_IF = 1'b1; Imem_Data_IF = 32'hDEAD_BEEF;
        Jump_control_ID = 1'b1; Jump_dst_ID = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (PC_IF !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", PC_IF, 32'h0); end
        checks++; if (Instr_IF !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", Instr_IF); end
        checks++; if (Instr_PC_IF !== 32'h0) begin errors++; $display("FAIL rst_ipc got %h exp 0", Instr_PC_IF); end
        checks++; if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", Instr_Valid_IF); end
        checks++; if (Imem_Req_IF !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", Imem_Req_IF); end
        checks++; if (Fetch_Count_IF !== 32'h0) begin errors++; $display("FAIL rst_count got %h exp 0", Fetch_Count_IF); end
        reset = 1'b1;
        #1;
        checks++; if (Flush_IF_ID !== 1'b0) begin errors++; $display("FAIL idle_flush got %b exp 0", Flush_IF_ID); end
        checks++; if (Imem_Req_IF !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", Imem_Req_IF); end
        tick();
        clear_in();
        #1;
        checks++; if (PC_IF !== 32'h0) begin errors++; $display("FAIL idle_ign_pc got %h exp 0", PC_IF); end
        checks++; if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL idle_ign_valid got %b exp 0", Instr_Valid_IF); end
        checks++; if (Imem_Req_IF !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", Imem_Req_IF); end
    endtask

    task automatic test_sequential;
        do_reset();
        Imem_Ack_IF = 1'b1;
        Imem_Data_IF = 32'hD000_0000;
        #1;
        checks++; if (Imem_Req_IF !== 1'b0) begin errors++; $display("FAIL seq_req0 got %b exp 0", Imem_Req_IF); end
        tick();
        Imem_Data_IF = 32'hD000_0001;
        #1;
        checks++; if (Imem_Addr_IF !== 32'h0) begin errors++; $display("FAIL seq_addr1 got %h exp 0", Imem_Addr_IF); end
        checks++; if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL seq_valid1 got %b exp 0", Instr_Valid_IF); end
        for (int k = 2; k < 8; k++) begin
            tick();
            Imem_Data_IF = 32'hD000_0000 + k;
            #1;
            checks++; if (Imem_Addr_IF !== 32'(4 * (k - 1))) begin errors++; $display("FAIL seq_addr k=%0d got %h exp %h", k, Imem_Addr_IF, 32'(4 * (k - 1))); end
            checks++; if (Instr_Valid_IF !== 1'b1) begin errors++; $display("FAIL seq_valid k=%0d got %b exp 1", k, Instr_Valid_IF); end
            checks++; if (Instr_IF !== 32'hD000_0000 + 32'(k - 1)) begin errors++; $display("FAIL seq_instr k=%0d got %h exp %h", k, Instr_IF, 32'hD000_0000 + 32'(k - 1)); end
            checks++; if (Instr_PC_IF !== 32'(4 * (k - 2))) begin errors++; $display("FAIL seq_ipc k=%0d got %h exp %h", k, Instr_PC_IF, 32'(4 * (k - 2))); end
            checks++; if (Fetch_Count_IF !== 32'(k - 2)) begin errors++; $display("FAIL seq_count k=%0d got %0d exp %0d", k, Fetch_Count_IF, k - 2); end
            checks++; if (PC_Plus_4_IF !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc4 k=%0d got %h exp %h", k, PC_Plus_4_IF, 32'(4 * k)); end
        end
    endtask

    task automatic test_wait_ack;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (Imem_Req_IF !== 1'b1 || Imem_Addr_IF !== 32'h0) begin errors++; $display("FAIL wait_hold i=%0d got %b/%h exp 1/0", i, Imem_Req_IF, Imem_Addr_IF); end
            tick();
        end
        Imem_Ack_IF = 1'b1; Imem_Data_IF = 32'h1234_5678;
        #1;
        checks++; if (Imem_Req_IF !== 1'b1 || Imem_Addr_IF !== 32'h0) begin errors++; $display("FAIL wait_ack_hold got %b/%h exp 1/0", Imem_Req_IF, Imem_Addr_IF); end
        tick();
        Imem_Ack_IF = 1'b0;
        #1;
        checks++; if (Instr_IF !== 32'h1234_5678) begin errors++; $display("FAIL wait_instr got %h exp 12345678", Instr_IF); end
        checks++; if (Instr_Valid_IF !== 1'b1) begin errors++; $display("FAIL wait_valid got %b exp 1", Instr_Valid_IF); end
        checks++; if (PC_IF !== 32'h4) begin errors++; $display("FAIL wait_pc got %h exp 4", PC_IF); end
        tick();
        #1;
        checks++; if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL wait_drop got %b exp 0", Instr_Valid_IF); end
        checks++; if (Fetch_Count_IF !== 32'h1) begin errors++; $display("FAIL wait_count got %0d exp 1", Fetch_Count_IF); end
        checks++; if (PC_IF !== 32'h4) begin errors++; $display("FAIL wait_pc_once got %h exp 4", PC_IF); end
    endtask

    task automatic test_stall;
        do_reset();
        Instr_Ready_ID = 1'b0;
        Imem_Ack_IF = 1'b1; Imem_Data_IF = 32'hCAFE_0000;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            Imem_Data_IF = 32'hBAD0_0000 + i;
            #1;
            checks++; if (Imem_Req_IF !== 1'b0) begin errors++; $display("FAIL stall_req i=%0d got %b exp 0", i, Imem_Req_IF); end
            checks++; if (Instr_IF !== 32'hCAFE_0000 || Instr_PC_IF !== 32'h0) begin errors++; $display("FAIL stall_hold i=%0d got %h/%h exp cafe0000/0", i, Instr_IF, Instr_PC_IF); end
            checks++; if (Fetch_Count_IF !== 32'h0 || PC_IF !== 32'h4) begin errors++; $display("FAIL stall_frozen i=%0d got %0d/%h exp 0/4", i, Fetch_Count_IF, PC_IF); end
            tick();
        end
        Instr_Ready_ID = 1'b1; Imem_Data_IF = 32'hCAFE_0004;
        #1;
        checks++; if (Imem_Req_IF !== 1'b1 || Imem_Addr_IF !== 32'h4) begin errors++; $display("FAIL stall_resume got %b/%h exp 1/4", Imem_Req_IF, Imem_Addr_IF); end
        tick();
        #1;
        checks++; if (Instr_IF !== 32'hCAFE_0004 || Instr_PC_IF !== 32'h4) begin errors++; $display("FAIL stall_next got %h/%h exp cafe0004/4", Instr_IF, Instr_PC_IF); end
        checks++; if (Fetch_Count_IF !== 32'h1) begin errors++; $display("FAIL stall_count got %0d exp 1", Fetch_Count_IF); end
    endtask

    task automatic test_jump_priority;
        do_reset();
        tick();
        Imem_Ack_IF = 1'b1; Imem_Data_IF = 32'h5555_5555;
        Jump_control_ID = 1'b1; Jump_dst_ID = 32'h400;
        PCSrc_ID = 1'b1; Branch_Dest_ID = 32'h800;
        #1;
        checks++; if (Flush_IF_ID !== 1'b1) begin errors++; $display("FAIL jmp_flush got %b exp 1", Flush_IF_ID); end
        tick();
        clear_in();
        #1;
        checks++; if (PC_IF !== 32'h400) begin errors++; $display("FAIL jmp_pc got %h exp 400", PC_IF); end
        checks++; if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL jmp_valid got %b exp 0", Instr_Valid_IF); end
        checks++; if (Flush_IF_ID !== 1'b0) begin errors++; $display("FAIL jmp_flush_off got %b exp 0", Flush_IF_ID); end
        checks++; if (Imem_Req_IF !== 1'b1 || Imem_Addr_IF !== 32'h400) begin errors++; $display("FAIL jmp_req got %b/%h exp 1/400", Imem_Req_IF, Imem_Addr_IF); end
    endtask

    task automatic test_drain;
        do_reset();
        tick();
        PCSrc_ID = 1'b1; Branch_Dest_ID = 32'h1002;
        #1;
        checks++; if (Flush_IF_ID !== 1'b1) begin errors++; $display("FAIL drn_flush1 got %b exp 1", Flush_IF_ID); end
        tick();
        PCSrc_ID = 1'b0; Imem_Ack_IF = 1'b1; Imem_Data_IF = 32'h0000_0BAD;
        #1;
        checks++; if (Imem_Req_IF !== 1'b1 || Imem_Addr_IF !== 32'h0) begin errors++; $display("FAIL drn_hold got %b/%h exp 1/0", Imem_Req_IF, Imem_Addr_IF); end
        tick();
        Imem_Ack_IF = 1'b0; Jump_control_ID = 1'b1; Jump_dst_ID = 32'h3000;
        #1;
        checks++; if (Imem_Addr_IF !== 32'h1000) begin errors++; $display("FAIL drn_addr got %h exp 1000", Imem_Addr_IF); end
        checks++; if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL drn_stale got %b exp 0", Instr_Valid_IF); end
        checks++; if (Flush_IF_ID !== 1'b1) begin errors++; $display("FAIL drn_flush2 got %b exp 1", Flush_IF_ID); end
        tick();
        Jump_control_ID = 1'b0; PCSrc_ID = 1'b1; Branch_Dest_ID = 32'h1FFF;
        #1;
        checks++; if (Flush_IF_ID !== 1'b1 || Imem_Addr_IF !== 32'h1000) begin errors++; $display("FAIL drn_redir got %b/%h exp 1/1000", Flush_IF_ID, Imem_Addr_IF); end
        tick();
        Branch_Dest_ID = 32'h2000; Imem_Ack_IF = 1'b1; Imem_Data_IF = 32'h0000_0BA2;
        #1;
        checks++; if (Flush_IF_ID !== 1'b1 || Imem_Req_IF !== 1'b1) begin errors++; $display("FAIL drn_ackredir got %b/%b exp 1/1", Flush_IF_ID, Imem_Req_IF); end
        tick();
        clear_in();
        #1;
        checks++; if (Imem_Addr_IF !== 32'h2000) begin errors++; $display("FAIL drn_latest got %h exp 2000", Imem_Addr_IF); end
        checks++; if (Instr_Valid_IF !== 1'b0 || Fetch_Count_IF !== 32'h0) begin errors++; $display("FAIL drn_empty got %b/%0d exp 0/0", Instr_Valid_IF, Fetch_Count_IF); end
    endtask

    task automatic test_wrap_and_reset;
        do_reset();
        tick();
        Imem_Ack_IF = 1'b1; Jump_control_ID = 1'b1; Jump_dst_ID = 32'hFFFF_FFFC;
        #1;
        tick();
        Jump_control_ID = 1'b0; Imem_Data_IF = 32'h7777_7777;
        #1;
        checks++; if (PC_IF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", PC_IF); end
        checks++; if (PC_Plus_4_IF !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", PC_Plus_4_IF); end
        tick();
        Imem_Ack_IF = 1'b0;
        #1;
        checks++; if (PC_IF !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", PC_IF); end
        checks++; if (Instr_PC_IF !== 32'hFFFF_FFFC || Instr_IF !== 32'h7777_7777) begin errors++; $display("FAIL wrap_instr got %h/%h exp fffffffc/77777777", Instr_PC_IF, Instr_IF); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (Imem_Req_IF !== 1'b1 || Fetch_Count_IF !== 32'h1) begin errors++; $display("FAIL mid_pre got %b/%0d exp 1/1", Imem_Req_IF, Fetch_Count_IF); end
        tick();
        #1;
        checks++; if (Instr_IF !== 32'h0 || Instr_PC_IF !== 32'h0) begin errors++; $display("FAIL mid_instr got %h/%h exp 0/0", Instr_IF, Instr_PC_IF); end
        checks++; if (Instr_Valid_IF !== 1'b0 || Imem_Req_IF !== 1'b0) begin errors++; $display("FAIL mid_vr got %b/%b exp 0/0", Instr_Valid_IF, Imem_Req_IF); end
        checks++; if (Fetch_Count_IF !== 32'h0 || PC_IF !== 32'h0) begin errors++; $display("FAIL mid_cnt_pc got %0d/%h exp 0/0", Fetch_Count_IF, PC_IF); end
        reset = 1'b1; Imem_Ack_IF = 1'b1; Imem_Data_IF = 32'h0BAD_0BAD;
        tick();
        Imem_Ack_IF = 1'b0;
        #1;
        checks++; if (Instr_Valid_IF !== 1'b0 || PC_IF !== 32'h0) begin errors++; $display("FAIL mid_stale got %b/%h exp 0/0", Instr_Valid_IF, PC_IF); end
        checks++; if (Imem_Req_IF !== 1'b1) begin errors++; $display("FAIL mid_req got %b exp 1", Imem_Req_IF); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clear_in();
        test_reset();
        test_sequential();
        test_wait_ack();
        test_stall();
        test_jump_priority();
        test_drain();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
